// File: rtl/btpipe_pkg.sv
// Shared definitions for the okBTPipeOut sequencer: FSM state encoding,
// default sample width and a saturating counter helper.
package btpipe_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        XFER  = 2'd3
    } btpipe_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/btpipe_fifo.sv
// Synchronous FIFO with registered read data, wrap-bit pointers and a
// synchronous flush. A push into a full FIFO succeeds when a pop happens in the same cycle.
module btpipe_fifo
    import btpipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  pop,
    output logic                  push_ok,
    output logic                  pop_ok,
    output logic [DATA_W-1:0]     rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic [DEPTH_LOG2-1:0] widx;
    logic [DEPTH_LOG2-1:0] ridx;

    assign widx  = wptr[DEPTH_LOG2-1:0];
    assign ridx  = rptr[DEPTH_LOG2-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) && (widx == ridx);
    assign level = wptr - rptr;

    // Flush wins over both ports; the pop frees the slot the push needs when full.
    assign pop_ok  = pop & ~clr & ~empty;
    assign push_ok = push & ~clr & (~full | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[ridx];
            end
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[widx] <= wdata;
        end
    end

endmodule

// File: rtl/btpipe_out_ctrl.sv
// Block sequencer between a free-running sample source and an okBTPipeOut endpoint.
// Optional internal counter source is enabled with `define BTPIPE_TEST_PATTERN_EN.
module btpipe_out_ctrl
    import btpipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  ti_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     src_data,
    input  logic                  src_valid,
`ifdef BTPIPE_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic                  ep_ready,
    output logic [DATA_W-1:0]     ep_datain,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           overflow_cnt,
    output logic                  underflow,
    output btpipe_state_t         state
);

    // Handshake: the source pushes whenever src_valid is high (no backpressure);
    // the endpoint pops one word per ep_read and sees it on ep_datain one cycle later.

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] BLOCK_LVL = CNT_W'(BLOCK_WORDS);

    logic                wr_req;
    logic [DATA_W-1:0]   wr_data;
    logic                push_ok;
    logic                pop_ok;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    lvl_nxt;
    logic [CNT_W-1:0]    blk_cnt;
    logic [CNT_W-1:0]    blk_cnt_nxt;
    btpipe_state_t       state_nxt;
    logic                ovf_hit;

    assign wr_req = src_valid & enable;

`ifdef BTPIPE_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_cnt;

    assign wr_data = test_mode ? pat_cnt : src_data;

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            pat_cnt <= '0;
        end else if (push_ok && test_mode) begin
            pat_cnt <= pat_cnt + 1'b1;
        end
    end
`else
    assign wr_data = src_data;
`endif

    btpipe_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (ti_clk),
        .rst     (reset),
        .clr     (clear),
        .push    (wr_req),
        .wdata   (wr_data),
        .pop     (ep_read),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .rdata   (ep_datain),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    // Level as it will be after this cycle's push/pop, used at block end.
    assign lvl_nxt = fifo_level + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign ovf_hit = wr_req & full & ~pop_ok & ~clear;

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            overflow_cnt <= '0;
            underflow    <= 1'b0;
        end else if (clear) begin
            overflow_cnt <= '0;
            underflow    <= 1'b0;
        end else begin
            if (ovf_hit) begin
                overflow_cnt <= sat_inc16(overflow_cnt);
            end
            if (ep_read && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            blk_cnt <= '0;
        end else begin
            state   <= state_nxt;
            blk_cnt <= blk_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        blk_cnt_nxt = blk_cnt;
        ep_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (fifo_level >= BLOCK_LVL) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                ep_ready = 1'b1;
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (ep_blockstrobe) begin
                    blk_cnt_nxt = BLOCK_LVL;
                    state_nxt   = XFER;
                end
            end
            XFER: begin
                // A disable only takes effect once the block in flight has drained.
                if (pop_ok) begin
                    blk_cnt_nxt = blk_cnt - 1'b1;
                    if (blk_cnt <= CNT_W'(1)) begin
                        blk_cnt_nxt = '0;
                        if (!enable) begin
                            state_nxt = IDLE;
                        end else if (lvl_nxt >= BLOCK_LVL) begin
                            state_nxt = READY;
                        end else begin
                            state_nxt = FILL;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (clear) begin
            state_nxt   = IDLE;
            blk_cnt_nxt = '0;
        end
    end

endmodule
